// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared access-size encodings, FSM states, latched command record and request check for dmem_arbiter.
package dmem_pkg;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [1:0]             size;
    logic                   uns;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   owner;
  } cmd_t;
  // A request is rejected for an unused size code, an unsigned word load
  // (the memory has no such mode), or a misaligned half/word when checking.
  function automatic logic bad_req(input logic we, input logic [1:0] lsb, input logic [1:0] size,
                                   input logic uns, input logic chk_align);
    return size == 2'b00 || (uns && size == SZ_WORD && !we) ||
           (chk_align && ((size == SZ_HALF && lsb[0]) || (size == SZ_WORD && lsb != 2'b00)));
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_port_if: one requester port of dmem_arbiter.
//   master: drives req/we/addr/size/uns/wdata, receives gnt/rvalid/err
//   slave : the arbiter side of the same signals
interface dmem_port_if #(
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
);
  logic              req, we, uns, gnt, rvalid, err;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [DATA_W-1:0] wdata;
  modport master (output req, we, addr, size, uns, wdata, input gnt, rvalid, err);
  modport slave (input req, we, addr, size, uns, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// dmem_rr_picker: 2-way grant selection; sel_o = index of the winning port.
//   clk, rst_n : clock, async active-low reset (rr_last resets to 1 so port 0 wins the first tie)
//   req_i      : {port1, port0} requests
//   adv_i      : a grant is taken this cycle; remember the winner
//   sel_o      : 0 = port 0 wins, 1 = port 1 wins
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins ties.
module dmem_rr_picker
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       sel_o
);
  logic rr_last_q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign sel_o = !req_i[0];
`else
  assign sel_o = &req_i ? !rr_last_q : req_i[1];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last_q <= 1'b1;
    else if (adv_i) rr_last_q <= sel_o;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-ported data memory.
//   clk, rst_n         : clock, async active-low reset
//   p0, p1             : requester ports (p0 = load/store unit, p1 = debug/DMA loader)
//   rdata              : shared response data, valid with either rvalid
//   mem_*              : data-memory strobes/fields, non-zero only in ISSUE
//   mem_rdata          : registered read data from the memory
// Build option DMEM_ARB_FIXED_PRIO_EN: fixed priority to port 0 instead of round-robin.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_port_if.slave        p0,
  dmem_port_if.slave        p1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_signed_unsigned,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state_q;
  cmd_t   cmd_q, cmd_d;
  logic   err_q, sel, gnt, bad, issue, resp;
  dmem_rr_picker u_pick (.clk, .rst_n, .req_i({p1.req, p0.req}), .adv_i(gnt), .sel_o(sel));
  // Qualified by rst_n so no grant is visible while reset is held.
  assign gnt = rst_n && state_q == ST_IDLE && (p0.req || p1.req);
  always_comb begin
    cmd_d.we    = sel ? p1.we : p0.we;
    cmd_d.addr  = sel ? p1.addr : p0.addr;
    cmd_d.size  = sel ? p1.size : p0.size;
    cmd_d.uns   = sel ? p1.uns : p0.uns;
    cmd_d.wdata = sel ? p1.wdata : p0.wdata;
    cmd_d.owner = sel;
  end
  assign bad = bad_req(cmd_d.we, cmd_d.addr[1:0], cmd_d.size, cmd_d.uns, CHECK_ALIGN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (gnt) begin
          cmd_q   <= cmd_d;
          err_q   <= bad;
          state_q <= bad ? ST_RESP : ST_ISSUE;
        end
        ST_ISSUE: state_q <= ST_RESP;
        default:  state_q <= ST_IDLE;
      endcase
    end
  assign issue               = state_q == ST_ISSUE;
  assign resp                = state_q == ST_RESP;
  assign mem_read            = issue && !cmd_q.we;
  assign mem_write           = issue && cmd_q.we;
  assign mem_signed_unsigned = mem_read && cmd_q.uns;
  assign mem_size            = issue ? cmd_q.size : 2'b00;
  assign mem_addr            = issue ? cmd_q.addr : '0;
  assign mem_wdata           = issue ? cmd_q.wdata : '0;
  assign p0.gnt              = gnt && !sel;
  assign p1.gnt              = gnt && sel;
  assign p0.rvalid           = resp && !cmd_q.owner;
  assign p1.rvalid           = resp && cmd_q.owner;
  assign p0.err              = p0.rvalid && err_q;
  assign p1.err              = p1.rvalid && err_q;
  assign rdata               = resp && !cmd_q.we && !err_q ? mem_rdata : '0;
endmodule
